// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the memory access sequencer: FSM states,
// control-bus bit positions and byte-enable lane codes.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int CTRL_ENA = 2;
  localparam int CTRL_RW  = 1;
  localparam int CTRL_WB  = 0;

  localparam logic [1:0] BE_WORD = 2'b11;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;

  // Byte enables for an access: full word, or the lane picked by address bit 0.
  function automatic logic [1:0] lane_be(input logic byte_acc, input logic odd);
    if (!byte_acc) return BE_WORD;
    return odd ? BE_HI : BE_LO;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: byte enables and replicated write data for
// an outgoing command, and zero-extended lane extraction for returning read data.
module mem_lane_align
  import cpu_mem_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              byte_acc,
  input  logic              odd,
  input  logic [DATA_W-1:0] wdata_in,
  output logic [1:0]        be,
  output logic [DATA_W-1:0] wdata_lane,
  input  logic [1:0]        rd_be,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] rdata_ext
);

  assign be         = lane_be(byte_acc, odd);
  assign wdata_lane = byte_acc ? {(DATA_W/8){wdata_in[7:0]}} : wdata_in;

  // The registered byte enables of the access in flight select the read lane.
  always_comb begin
    // NOTE: default assignment first so no path leaves rdata_ext unassigned (no latch).
    rdata_ext = '0;
    case (rd_be)
      BE_LO:   rdata_ext[7:0] = rdata[7:0];
      BE_HI:   rdata_ext[7:0] = rdata[DATA_W-1 -: 8];
      default: rdata_ext      = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access sequencer: one read/write per ctrl strobe over a req/ack memory
// port with timeout. Define MEM_ALIGN_CHECK_EN to fault misaligned word accesses.
module mem_access_unit
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [2:0]        ctrl,
  input  logic [ADDR_W-1:0] mar,
  input  logic [DATA_W-1:0] mdr_in,
  output logic [DATA_W-1:0] mdr_out,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int               CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  state_t            state;
  logic [CNT_W-1:0]  wait_cnt;
  logic [1:0]        req_be;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0] rd_ext;

  mem_lane_align #(.DATA_W(DATA_W)) u_lane_align (
    .byte_acc   (ctrl[CTRL_WB]),
    .odd        (mar[0]),
    .wdata_in   (mdr_in),
    .be         (req_be),
    .wdata_lane (req_wdata),
    .rd_be      (mem_be),
    .rdata      (mem_rdata),
    .rdata_ext  (rd_ext)
  );

`ifdef MEM_ALIGN_CHECK_EN
  logic misaligned;
  assign misaligned = ~ctrl[CTRL_WB] & mar[0];
`endif

  // The memory-side registers double as the latched command for the whole access.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      mdr_out   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
    end else begin
      // NOTE: non-blocking assignments for all state so every register updates from pre-edge values.
      done  <= 1'b0;
      fault <= 1'b0;
      case (state)
        IDLE: begin
          if (ctrl[CTRL_ENA]) begin
            busy      <= 1'b1;
            wait_cnt  <= '0;
            mem_we    <= ctrl[CTRL_RW];
            mem_addr  <= {mar[ADDR_W-1:1], 1'b0};
            mem_be    <= req_be;
            mem_wdata <= req_wdata;
`ifdef MEM_ALIGN_CHECK_EN
            if (misaligned) begin
              state <= DONE;
            end else begin
              mem_req <= 1'b1;
              state   <= ISSUE;
            end
`else
            mem_req <= 1'b1;
            state   <= ISSUE;
`endif
          end
        end

        ISSUE: begin
          wait_cnt <= wait_cnt + 1'b1;
          state    <= WAIT;
        end

        WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= DONE;
            if (!mem_we) mdr_out <= rd_ext;
          end else if (wait_cnt == CNT_MAX) begin
            mem_req <= 1'b0;
            done    <= 1'b1;
            fault   <= 1'b1;
            busy    <= 1'b0;
            state   <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        DONE: begin
          wait_cnt <= '0;
`ifdef MEM_ALIGN_CHECK_EN
          // A rejected misaligned access arrives here still busy and owes its pulse.
          if (busy) begin
            done  <= 1'b1;
            fault <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state <= IDLE;
          end
`else
          state <= IDLE;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized commands
// checked against a transaction-level model of latency, lanes, faults and MDR.
module tb_mem_access_unit;

  localparam int TIMEOUT = 15;

  logic        clock;
  logic        reset_n;
  logic [2:0]  ctrl;
  logic [15:0] mar;
  logic [15:0] mdr_in;
  logic [15:0] mdr_out;
  logic        busy;
  logic        done;
  logic        fault;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [1:0]  mem_be;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  int checks;
  int failures;
  logic [15:0] mdr_model;

  mem_access_unit #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(TIMEOUT)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .ctrl      (ctrl),
    .mar       (mar),
    .mdr_in    (mdr_in),
    .mdr_out   (mdr_out),
    .busy      (busy),
    .done      (done),
    .fault     (fault),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected lane enables and read data straight from the lane rules.
  function automatic logic [1:0] exp_be(input logic wb, input logic odd);
    if (!wb) return 2'b11;
    return odd ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [15:0] exp_read(input logic wb, input logic odd, input logic [15:0] rd);
    if (!wb) return rd;
    return odd ? {8'h00, rd[15:8]} : {8'h00, rd[7:0]};
  endfunction

  // One command. ack_k = index of the edge after acceptance at which ack is
  // sampled (0 = never). noise adds strobes/garbage on ctrl while busy and a
  // spurious ack during ISSUE, none of which may change the outcome.
  task automatic run_cmd(input logic rw, input logic wb, input logic [15:0] addr,
                         input logic [15:0] wdata, input int ack_k,
                         input logic [15:0] rdata, input bit noise);
    bit   mis_chk;
    bit   got_done;
    bit   exp_fault;
    int   k_done;
    int   exp_k;
    int   reqs;
    logic prev_req;
`ifdef MEM_ALIGN_CHECK_EN
    mis_chk = !wb && addr[0];
`else
    mis_chk = 1'b0;
`endif
    @(negedge clock);
    ctrl    = {1'b1, rw, wb};
    mar     = addr;
    mdr_in  = wdata;
    mem_ack = 1'b0;
    @(posedge clock); #1;
    check("busy_accept", 32'(busy), 32'd1);
    if (mis_chk) begin
      check("req_misaligned", 32'(mem_req), 32'd0);
    end else begin
      check("req_accept", 32'(mem_req), 32'd1);
      check("we", 32'(mem_we), 32'(rw));
      check("addr", 32'(mem_addr), 32'({addr[15:1], 1'b0}));
      check("be", 32'(mem_be), 32'(exp_be(wb, addr[0])));
      if (rw) check("wdata", 32'(mem_wdata), 32'(wb ? {2{wdata[7:0]}} : wdata));
    end
    reqs     = int'(mem_req);
    prev_req = mem_req;
    got_done = 1'b0;
    k_done   = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (noise) begin
        ctrl   = 3'($urandom());
        mar    = 16'($urandom());
        mdr_in = 16'($urandom());
      end else begin
        ctrl = 3'b000;
      end
      mem_ack   = (k == ack_k) || (noise && k == 1 && ($urandom() % 2 == 0));
      mem_rdata = (k == ack_k) ? rdata : 16'($urandom());
      @(posedge clock); #1;
      if (mem_req && !prev_req) reqs++;
      prev_req = mem_req;
      if (done) begin
        got_done = 1'b1;
        k_done   = k;
        break;
      end
      check("fault_without_done", 32'(fault), 32'd0);
      if (!mis_chk) check("req_held", 32'(mem_req), 32'd1);
    end

    exp_fault = mis_chk || !(ack_k >= 2 && ack_k <= TIMEOUT + 1);
    exp_k     = mis_chk ? 1 : (exp_fault ? TIMEOUT + 1 : ack_k);
    check("done_seen", 32'(got_done), 32'd1);
    check("done_latency", 32'(k_done), 32'(exp_k));
    check("fault", 32'(fault), 32'(exp_fault));
    check("busy_at_done", 32'(busy), 32'd0);
    check("req_at_done", 32'(mem_req), 32'd0);
    if (!exp_fault && !rw) mdr_model = exp_read(wb, addr[0], rdata);
    check("mdr_out", 32'(mdr_out), 32'(mdr_model));
    check("req_count", 32'(reqs), mis_chk ? 32'd0 : 32'd1);

    @(negedge clock);
    ctrl    = 3'b000;
    mem_ack = 1'b0;
    @(posedge clock); #1;
    check("done_one_cycle", 32'(done), 32'd0);
    check("fault_after_done", 32'(fault), 32'd0);
  endtask

  // Idle cycles with a strobe-free bus and stray acks: nothing may happen.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      ctrl    = {1'b0, 2'($urandom())};
      mem_ack = 1'($urandom());
      @(posedge clock); #1;
      check("idle_done", 32'(done), 32'd0);
      check("idle_req", 32'(mem_req), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
    end
    @(negedge clock);
    mem_ack = 1'b0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    mdr_model = 16'h0000;
    reset_n   = 1'b0;
    ctrl      = 3'b000;
    mar       = 16'h0000;
    mdr_in    = 16'h0000;
    mem_rdata = 16'h0000;
    mem_ack   = 1'b0;
    #12;
    check("rst_mdr_out", 32'(mdr_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_be", 32'(mem_be), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    idle_cycles(2);

    // Directed cases.
    run_cmd(1'b0, 1'b0, 16'h1000, 16'h0000, 2, 16'hBEEF, 1'b0);
    run_cmd(1'b1, 1'b1, 16'h2001, 16'h00A5, 2, 16'h0000, 1'b0);
    run_cmd(1'b0, 1'b1, 16'h0003, 16'h0000, 3, 16'h1234, 1'b0);
    run_cmd(1'b0, 1'b1, 16'h0002, 16'h0000, 2, 16'h1234, 1'b0);
    run_cmd(1'b0, 1'b0, 16'h3000, 16'h0000, 0, 16'h0000, 1'b0);
    run_cmd(1'b0, 1'b0, 16'h3002, 16'h0000, TIMEOUT + 1, 16'h5A5A, 1'b0);
    run_cmd(1'b0, 1'b0, 16'h3004, 16'h0000, TIMEOUT + 2, 16'hFFFF, 1'b0);
    run_cmd(1'b0, 1'b0, 16'h0101, 16'h0000, 3, 16'hC0DE, 1'b0);
    run_cmd(1'b1, 1'b0, 16'h4444, 16'h9876, 4, 16'h0000, 1'b1);
    idle_cycles(3);

    // Randomized commands.
    for (int t = 0; t < 40; t++) begin
      int sel;
      int ack_k;
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      ack_k = 0;
      else if (sel == 1) ack_k = int'($urandom_range(TIMEOUT, TIMEOUT + 2));
      else               ack_k = int'($urandom_range(2, 6));
      run_cmd(1'($urandom()), 1'($urandom()), 16'($urandom()), 16'($urandom()),
              ack_k, 16'($urandom()), 1'($urandom()));
      if ($urandom() % 4 == 0) idle_cycles(1);
    end

    // Reset in the middle of WAIT aborts at once and issues no done.
    @(negedge clock);
    ctrl = 3'b100;
    mar  = 16'h0040;
    @(negedge clock);
    ctrl = 3'b000;
    @(posedge clock);
    @(posedge clock);
    #2;
    check("pre_reset_req", 32'(mem_req), 32'd1);
    reset_n = 1'b0;
    #1;
    check("async_req", 32'(mem_req), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_mdr", 32'(mdr_out), 32'd0);
    mdr_model = 16'h0000;
    @(negedge clock);
    reset_n = 1'b1;
    idle_cycles(4);
    run_cmd(1'b0, 1'b1, 16'h0007, 16'h0000, 2, 16'hAB12, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory access sequencer sitting directly downstream of the control unit's MAR/MDR/control-register bus. Accepts one read or write command per strobe on the 3-bit control bus, drives a request/acknowledge interface to the memory array with correct byte-lane steering, and returns read data to the MDR plus a one-cycle completion pulse the control unit waits on. Bounds memory latency with a timeout and flags faulting accesses.

## Interface
- ADDR_W, 16, MAR/memory address width
- DATA_W, 16, word width (two byte lanes, little-endian)
- TIMEOUT, 15, max WAIT cycles before abort (counter width $clog2(TIMEOUT+1))
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- ctrl  in  3  [2]=ENA strobe, [1]=R/W (0 read, 1 write), [0]=W/B (0 word, 1 byte)
- mar  in  ADDR_W  access address
- mdr_in  in  DATA_W  write data (byte writes use [7:0])
- mdr_out  out  DATA_W  read data; byte reads zero-extended
- busy  out  1  command in flight
- done  out  1  one-cycle completion pulse
- fault  out  1  valid with done; 1 = timeout or misaligned word
- mem_req  out  1  request to memory, held until ack
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  word-aligned address (bit0 = 0)
- mem_be  out  2  byte enables, [1]=high lane
- mem_wdata  out  DATA_W  write data, lane-steered
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- mem_ack  in  1  memory completion

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: ctrl[2]=1 latches ctrl[1:0], mar, mdr_in; -> ISSUE; busy=1. ctrl[2] while busy is ignored (no queueing).
- ISSUE: mem_req=1 with address/we/be/wdata from latched command; -> WAIT.
- WAIT: mem_req held, outputs stable. mem_ack=1 -> DONE, capture result. Counter reaching TIMEOUT without ack -> DONE with fault=1, mem_req dropped.
- DONE: done=1 for exactly one cycle, busy=0 from this cycle; -> IDLE. New strobe is accepted in the cycle after DONE.
- Lane steering: word access mem_be=2'b11, mem_wdata=mdr; byte access at even address mem_be=2'b01, odd mem_be=2'b10; byte write data replicated on both lanes. Byte read: mdr_out={8'h00, selected lane}.
- Read completion updates mdr_out; write completion and any fault leave mdr_out unchanged.
- Misaligned word (mar[0]=1, W/B=0): see Configuration.

## Timing
- Reset: state IDLE; mdr_out=0, busy=0, done=0, fault=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, counter 0. Reset mid-access aborts immediately (mem_req falls asynchronously); no done issued.
- Strobe sampled at edge N: ISSUE after N, mem_req visible cycle N+1. Ack sampled at edge N+2 earliest; done high cycle N+3. Minimum strobe-to-done latency 3 cycles; each extra wait cycle adds 1.
- Timeout: done+fault exactly TIMEOUT+2 cycles after accept-cycle edge if ack never arrives. Ack on the same edge the counter hits TIMEOUT wins (normal completion, fault=0).
- mem_ack outside WAIT is ignored.
- done and fault are registered; fault=0 whenever done=0.

## Configuration
- MEM_ALIGN_CHECK_EN defined: misaligned word access skips ISSUE, goes IDLE->DONE with fault=1 (done 2 cycles after accept-edge); no memory request issued.
- Undefined: misaligned word aligns down (mar[0] forced to 0), completes normally, fault only on timeout.

## Structure
- Package cpu_mem_pkg: state enum (IDLE, ISSUE, WAIT, DONE), ctrl bit indices CTRL_ENA=2, CTRL_RW=1, CTRL_WB=0, lane constants BE_WORD/BE_LO/BE_HI.
- One sub-module: mem_lane_align (combinational byte-lane steering for be, wdata, read extraction), instantiated once.

## Test plan
- Word read: mar=16'h1000, ctrl=3'b100, ack one cycle after req, rdata=16'hBEEF -> mem_addr=16'h1000, be=2'b11, done on cycle 3, mdr_out=16'hBEEF, fault=0.
- Byte write odd: mar=16'h2001, mdr_in=16'h00A5, ctrl=3'b111 -> mem_we=1, be=2'b10, wdata=16'hA5A5, mdr_out unchanged.
- Byte read odd: mar=16'h0003, rdata=16'h1234 -> mdr_out=16'h0012; even mar=16'h0002 -> 16'h0034.
- Timeout: no ack, TIMEOUT=15 -> done+fault at cycle 17, mem_req low, mdr_out unchanged; ack arriving on cycle 16 instead -> fault=0.
- Misaligned word mar=16'h0101 read: with MEM_ALIGN_CHECK_EN -> no mem_req, done+fault at cycle 2; without -> mem_addr=16'h0100, normal completion.
- Reset asserted during WAIT -> mem_req, busy low immediately, no done; strobe during busy -> ignored, only one mem_req observed.
